uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1000, meaning cycles a granted requester may idle mid-packet before forced release (legal 1..65535).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports s0_data / s1_data  input  8  requester byte.
REQ-005 SHALL have ports s0_valid / s1_valid  input  1  requester byte available.
REQ-006 SHALL have ports s0_last / s1_last  input  1  current byte ends the packet.
REQ-007 SHALL have ports s0_ready / s1_ready  output  1  byte accepted this cycle.
REQ-008 SHALL have port tx_data  output  8  byte to UART TX FIFO push_data.
REQ-009 SHALL have port push  output  1  FIFO push strobe.
REQ-010 SHALL have port tx_fifo_full  input  1  FIFO full flag.
REQ-011 SHALL have port grant  output  2  one-hot registered owner (bit0=s0, bit1=s1), 00 when idle.
REQ-012 SHALL have port busy  output  1  high while a packet owns the FIFO.
REQ-013 SHALL have port timeout_err  output  1  one-cycle pulse on forced release.

Function
REQ-014 SHALL implement FSM states IDLE and BUSY; busy = (state==BUSY).
REQ-015 SHALL in IDLE with any sx_valid high, register grant to one requester and enter BUSY next cycle; no push in IDLE.
REQ-016 SHALL arbitrate round-robin: both valid -> grant requester not last granted; one valid -> grant it.
REQ-017 SHALL keep last-granted register, reset value = s1, so s0 wins the first contention.
REQ-018 SHALL in BUSY drive push = sel_valid & ~tx_fifo_full combinationally; sel_ready = push; non-granted ready = 0.
REQ-019 SHALL drive tx_data = granted sx_data in BUSY, 8'h00 in IDLE.
REQ-020 SHALL on push with sel_last=1 return to IDLE next cycle, clear grant, update last-granted.
REQ-021 SHALL never switch grant mid-packet; other requester waits regardless of its valid.
REQ-022 SHALL hold bytes while tx_fifo_full=1: push=0, ready=0, no data loss, no timeout counting.
REQ-023 SHALL count idle cycles in BUSY where sel_valid=0; counter clears on every push and on entry to BUSY.
REQ-024 SHALL, when idle count reaches TIMEOUT_CYC, return to IDLE, pulse timeout_err for exactly one cycle, update last-granted.
REQ-025 SHALL give minimum latency: valid rising in IDLE at cycle N -> first push at N+1 (FIFO not full); back-to-back packet from other requester first push 2 cycles after prior last push.
REQ-026 SHALL sustain one byte per cycle within a packet while valid and not full.

Reset
REQ-027 SHALL on reset (any time, incl. mid-packet) force IDLE, grant=00, push=0, s0_ready=s1_ready=0, tx_data=8'h00, busy=0, timeout_err=0, idle counter=0, last-granted=s1.
REQ-028 SHALL resume arbitration on the first rising clk edge after reset deasserts.

Verification
REQ-029 SHALL cover: s0 sends 3-byte packet 8'hA1,8'hA2,8'hA3(last), FIFO not full -> push for 3 consecutive cycles starting 1 cycle after valid, grant=01, then IDLE.
REQ-030 SHALL cover: s0 and s1 both valid from reset, 2-byte packets each -> s0 packet fully pushed first, then s1; next contention grants s0.
REQ-031 SHALL cover: tx_fifo_full=1 for 5 cycles mid-packet -> push=0 and ready=0 during stall, byte order unchanged, no timeout_err.
REQ-032 SHALL cover: TIMEOUT_CYC=4, s1 sends 1 byte without last then drops valid -> timeout_err pulse after 4 idle cycles, grant=00, pending s0 granted next.
REQ-033 SHALL cover: reset asserted during 4-byte packet after byte 2 -> all outputs at reset values immediately; after release, s0 restart granted normally.
REQ-034 SHALL cover: s1 valid continuously while s0 owns packet -> s1_ready=0 until s0 last byte pushed; s1 granted in next IDLE cycle.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Two-requester, packet-granular round-robin arbiter that feeds a single
//   UART TX FIFO. Once a requester is granted, it owns the FIFO until it
//   pushes a byte flagged last, or until it idles mid-packet for
//   TIMEOUT_CYC cycles. The other requester cannot take over before then.
//
// Parameters
//   TIMEOUT_CYC  idle cycles allowed mid-packet before forced release (1..65535)
//
// Ports
//   clk                 system clock, rising edge
//   reset               asynchronous, active-high reset
//   s0_/s1_data[7:0]    requester byte
//   s0_/s1_valid        requester byte available
//   s0_/s1_last         current byte ends the packet
//   s0_/s1_ready        byte accepted this cycle
//   tx_data[7:0]        byte to the FIFO push_data
//   push                FIFO push strobe
//   tx_fifo_full        FIFO full flag
//   grant[1:0]          registered one-hot owner (bit0=s0, bit1=s1), 00 when idle
//   busy                high while a packet owns the FIFO
//   timeout_err         one-cycle pulse on forced release
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] s0_data,
  input  logic       s0_valid,
  input  logic       s0_last,
  output logic       s0_ready,
  input  logic [7:0] s1_data,
  input  logic       s1_valid,
  input  logic       s1_last,
  output logic       s1_ready,
  output logic [7:0] tx_data,
  output logic       push,
  input  logic       tx_fifo_full,
  output logic [1:0] grant,
  output logic       busy,
  output logic       timeout_err
);

  // The idle counter counts 0..TIMEOUT_CYC-1; release fires on the idle
  // cycle that finds it at the top value, i.e. the TIMEOUT_CYC-th idle cycle.
  localparam logic [15:0] IDLE_LIMIT = 16'(TIMEOUT_CYC - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  grant_reg, grant_next;
  logic        last_s1_reg, last_s1_next;   // 1: s1 was granted most recently
  logic [15:0] idle_cnt_reg, idle_cnt_next;
  logic        timeout_err_reg, timeout_err_next;

  logic [1:0]  req_valid;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic [7:0]  req_data    [2];
  logic [7:0]  data_masked [2];

  logic        in_busy;
  logic        sel_valid;
  logic        sel_last;
  logic [7:0]  sel_data;
  logic        push_int;
  logic        idle_tick;

  assign req_valid   = {s1_valid, s0_valid};
  assign req_last    = {s1_last, s0_last};
  assign req_data[0] = s0_data;
  assign req_data[1] = s1_data;

  // grant_reg is one-hot or zero, so masking and OR-ing forms the data mux.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign data_masked[gi] = req_data[gi] & {8{grant_reg[gi]}};
      assign req_ready[gi]   = grant_reg[gi] & push_int;
    end
  endgenerate

  assign in_busy   = (state_reg == BUSY);
  assign sel_valid = |(req_valid & grant_reg);
  assign sel_last  = |(req_last & grant_reg);
  assign sel_data  = data_masked[0] | data_masked[1];

  assign push_int  = in_busy & sel_valid & ~tx_fifo_full;
  // A full FIFO is back-pressure, not requester idleness, so it freezes the count.
  assign idle_tick = in_busy & ~sel_valid & ~tx_fifo_full;

  assign push        = push_int;
  assign s0_ready    = req_ready[0];
  assign s1_ready    = req_ready[1];
  assign tx_data     = in_busy ? sel_data : 8'h00;
  assign grant       = grant_reg;
  assign busy        = in_busy;
  assign timeout_err = timeout_err_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      grant_reg       <= 2'b00;
      last_s1_reg     <= 1'b1;
      idle_cnt_reg    <= 16'd0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      grant_reg       <= grant_next;
      last_s1_reg     <= last_s1_next;
      idle_cnt_reg    <= idle_cnt_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    grant_next       = grant_reg;
    last_s1_next     = last_s1_reg;
    idle_cnt_next    = idle_cnt_reg;
    timeout_err_next = 1'b0;

    case (state_reg)
      IDLE: begin
        idle_cnt_next = 16'd0;
        if (|req_valid) begin
          state_next = BUSY;
          if (&req_valid) begin
            // Contention: favour whoever was not served last.
            grant_next = last_s1_reg ? 2'b01 : 2'b10;
          end else begin
            grant_next = req_valid;
          end
        end
      end

      BUSY: begin
        if (push_int) begin
          idle_cnt_next = 16'd0;
          if (sel_last) begin
            state_next   = IDLE;
            grant_next   = 2'b00;
            last_s1_next = grant_reg[1];
          end
        end else if (idle_tick) begin
          if (idle_cnt_reg == IDLE_LIMIT) begin
            state_next       = IDLE;
            grant_next       = 2'b00;
            last_s1_next     = grant_reg[1];
            idle_cnt_next    = 16'd0;
            timeout_err_next = 1'b1;
          end else begin
            idle_cnt_next = idle_cnt_reg + 16'd1;
          end
        end
      end

      default: begin
        state_next = IDLE;
        grant_next = 2'b00;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter (TIMEOUT_CYC = 4).
// Requester byte streams live in per-source queues; every byte the bench
// expects to reach the FIFO is pushed as {grant, data} to a scoreboard
// queue in the order the arbitration rules dictate and popped when the
// DUT pushes. Each scenario task adds its own cycle-level checks.
module tb_uart_tx_arbiter;

  logic       clk;
  logic       reset;
  logic [7:0] s0_data, s1_data;
  logic       s0_valid, s1_valid;
  logic       s0_last, s1_last;
  logic       s0_ready, s1_ready;
  logic [7:0] tx_data;
  logic       push;
  logic       tx_fifo_full;
  logic [1:0] grant;
  logic       busy;
  logic       timeout_err;

  uart_tx_arbiter #(.TIMEOUT_CYC(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .s0_data      (s0_data),
    .s0_valid     (s0_valid),
    .s0_last      (s0_last),
    .s0_ready     (s0_ready),
    .s1_data      (s1_data),
    .s1_valid     (s1_valid),
    .s1_last      (s1_last),
    .s1_ready     (s1_ready),
    .tx_data      (tx_data),
    .push         (push),
    .tx_fifo_full (tx_fifo_full),
    .grant        (grant),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  logic [8:0] q0 [$];      // {last, data} for s0
  logic [8:0] q1 [$];      // {last, data} for s1
  logic [9:0] exp_q [$];   // {grant, data} expected at the FIFO
  logic       full_n;      // tx_fifo_full to apply at the next edge
  logic       en0, en1;    // requester willing to present valid
  int         n_checks;
  int         n_pass;
  int         to_cnt;      // timeout_err pulses seen
  logic [9:0] mon_e;

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (timeout_err === 1'b1) to_cnt++;
    if (push === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected: got push grant=%b data=%02h, want no push", grant, tx_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ({grant, tx_data} !== mon_e)
          $display("FAIL sb_byte: got grant=%b data=%02h, want grant=%b data=%02h",
                   grant, tx_data, mon_e[9:8], mon_e[7:0]);
        else begin
          n_pass++;
          $display("push grant=%b data=%02h", grant, tx_data);
        end
      end
    end
  end

  task automatic drive_srcs();
    s0_valid = en0 && (q0.size() != 0);
    s0_data  = (q0.size() != 0) ? q0[0][7:0] : 8'h00;
    s0_last  = (q0.size() != 0) ? q0[0][8] : 1'b0;
    s1_valid = en1 && (q1.size() != 0);
    s1_data  = (q1.size() != 0) ? q1[0][7:0] : 8'h00;
    s1_last  = (q1.size() != 0) ? q1[0][8] : 1'b0;
  endtask

  // Advance one cycle: capture readies, let the edge happen, retire accepted
  // bytes, apply the next inputs, and return with outputs settled.
  task automatic tick();
    logic r0, r1;
    @(negedge clk);
    r0 = s0_ready;
    r1 = s1_ready;
    @(posedge clk);
    #1;
    if (r0 === 1'b1 && q0.size() != 0) void'(q0.pop_front());
    if (r1 === 1'b1 && q1.size() != 0) void'(q1.pop_front());
    tx_fifo_full = full_n;
    drive_srcs();
    #1;
  endtask

  task automatic drain(input int bound, output int left);
    int k;
    k = 0;
    while (((en0 && q0.size() != 0) || (en1 && q1.size() != 0) || exp_q.size() != 0) && k < bound) begin
      tick();
      k++;
    end
    tick();
    tick();
    left = exp_q.size();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({grant, busy, push, s0_ready, s1_ready, timeout_err, tx_data} !== 15'd0)
      $display("FAIL reset_outputs: got %b, want all zero",
               {grant, busy, push, s0_ready, s1_ready, timeout_err, tx_data});
    else n_pass++;
    reset = 1'b0;
    tick();
    n_checks++;
    if ({grant, busy} !== 3'b000)
      $display("FAIL reset_idle: got grant=%b busy=%b, want 00/0", grant, busy);
    else n_pass++;
    $display("test_reset done");
  endtask

  task automatic test_single_packet();
    int left;
    q0.push_back({1'b0, 8'hA1}); exp_q.push_back({2'b01, 8'hA1});
    q0.push_back({1'b0, 8'hA2}); exp_q.push_back({2'b01, 8'hA2});
    q0.push_back({1'b1, 8'hA3}); exp_q.push_back({2'b01, 8'hA3});
    tick();
    n_checks++;
    if ({push, grant, s0_ready} !== 4'b0000)
      $display("FAIL single_first_cycle: got push=%b grant=%b ready=%b, want 0/00/0", push, grant, s0_ready);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({push, s0_ready, grant, busy} !== 5'b11011)
        $display("FAIL single_push%0d: got push=%b ready=%b grant=%b busy=%b, want 1/1/01/1",
                 i, push, s0_ready, grant, busy);
      else n_pass++;
    end
    tick();
    n_checks++;
    if ({grant, busy, push} !== 4'b0000)
      $display("FAIL single_release: got grant=%b busy=%b push=%b, want 00/0/0", grant, busy, push);
    else n_pass++;
    drain(20, left);
    n_checks++;
    if (left !== 0) $display("FAIL single_drain: got %0d bytes missing, want 0", left);
    else n_pass++;
    $display("test_single_packet done");
  endtask

  task automatic test_contention();
    int left;
    reset = 1'b1;
    q0.push_back({1'b0, 8'hB0}); q0.push_back({1'b1, 8'hB1});
    q1.push_back({1'b0, 8'hC0}); q1.push_back({1'b1, 8'hC1});
    exp_q.push_back({2'b01, 8'hB0}); exp_q.push_back({2'b01, 8'hB1});
    exp_q.push_back({2'b10, 8'hC0}); exp_q.push_back({2'b10, 8'hC1});
    tick();
    n_checks++;
    if ({grant, push} !== 3'b000)
      $display("FAIL contend_in_reset: got grant=%b push=%b, want 00/0", grant, push);
    else n_pass++;
    reset = 1'b0;
    tick();
    n_checks++;
    if ({grant, push} !== 3'b011)
      $display("FAIL contend_first_grant: got grant=%b push=%b, want 01/1", grant, push);
    else n_pass++;
    drain(40, left);
    n_checks++;
    if (left !== 0 || busy !== 1'b0) $display("FAIL contend_drain: got %0d missing busy=%b, want 0/0", left, busy);
    else n_pass++;
    q0.push_back({1'b1, 8'hD0}); exp_q.push_back({2'b01, 8'hD0});
    q1.push_back({1'b1, 8'hE0}); exp_q.push_back({2'b10, 8'hE0});
    tick();
    tick();
    n_checks++;
    if (grant !== 2'b01) $display("FAIL contend_second_grant: got grant=%b, want 01", grant);
    else n_pass++;
    drain(40, left);
    n_checks++;
    if (left !== 0) $display("FAIL contend_second_drain: got %0d missing, want 0", left);
    else n_pass++;
    $display("test_contention done");
  endtask

  task automatic test_stall();
    int left;
    int t0;
    t0 = to_cnt;
    for (int i = 0; i < 4; i++) begin
      q0.push_back({(i == 3), 8'hF0 + 8'(i)});
      exp_q.push_back({2'b01, 8'hF0 + 8'(i)});
    end
    tick();
    tick();
    n_checks++;
    if (push !== 1'b1) $display("FAIL stall_first_push: got %b, want 1", push);
    else n_pass++;
    full_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if ({push, s0_ready, busy, timeout_err, grant} !== 6'b001001)
        $display("FAIL stall_cycle%0d: got push=%b ready=%b busy=%b tmo=%b grant=%b, want 0/0/1/0/01",
                 i, push, s0_ready, busy, timeout_err, grant);
      else n_pass++;
    end
    full_n = 1'b0;
    drain(40, left);
    n_checks++;
    if (left !== 0 || to_cnt !== t0)
      $display("FAIL stall_drain: got %0d missing, %0d timeouts, want 0/0", left, to_cnt - t0);
    else n_pass++;
    $display("test_stall done");
  endtask

  task automatic test_timeout();
    int left;
    q1.push_back({1'b0, 8'h61}); exp_q.push_back({2'b10, 8'h61});
    q1.push_back({1'b1, 8'h62});
    tick();
    tick();
    n_checks++;
    if ({grant, push} !== 3'b101) $display("FAIL tmo_grant_s1: got grant=%b push=%b, want 10/1", grant, push);
    else n_pass++;
    en1 = 1'b0;
    q0.push_back({1'b1, 8'h71}); exp_q.push_back({2'b01, 8'h71});
    tick();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({grant, busy, timeout_err, push} !== 5'b10100)
        $display("FAIL tmo_idle%0d: got grant=%b busy=%b tmo=%b push=%b, want 10/1/0/0",
                 i, grant, busy, timeout_err, push);
      else n_pass++;
      tick();
    end
    n_checks++;
    if ({grant, busy, timeout_err} !== 4'b0001)
      $display("FAIL tmo_release: got grant=%b busy=%b tmo=%b, want 00/0/1", grant, busy, timeout_err);
    else n_pass++;
    tick();
    n_checks++;
    if ({grant, timeout_err, push} !== 4'b0101)
      $display("FAIL tmo_next_grant: got grant=%b tmo=%b push=%b, want 01/0/1", grant, timeout_err, push);
    else n_pass++;
    drain(20, left);
    q1.delete();
    en1 = 1'b1;
    drive_srcs();
    n_checks++;
    if (left !== 0) $display("FAIL tmo_drain: got %0d missing, want 0", left);
    else n_pass++;
    $display("test_timeout done");
  endtask

  task automatic test_reset_mid();
    int left;
    for (int i = 0; i < 4; i++) begin
      q0.push_back({(i == 3), 8'h90 + 8'(i)});
      exp_q.push_back({2'b01, 8'h90 + 8'(i)});
    end
    repeat (4) tick();
    n_checks++;
    if ({push, tx_data} !== 9'h192) $display("FAIL rstmid_third: got push=%b data=%02h, want 1/92", push, tx_data);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({grant, busy, push, s0_ready, s1_ready, timeout_err, tx_data} !== 15'd0)
      $display("FAIL rstmid_outputs: got %b, want all zero",
               {grant, busy, push, s0_ready, s1_ready, timeout_err, tx_data});
    else n_pass++;
    q0.delete();
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      q0.push_back({(i == 3), 8'h90 + 8'(i)});
      exp_q.push_back({2'b01, 8'h90 + 8'(i)});
    end
    drive_srcs();
    tick();
    reset = 1'b0;
    tick();
    n_checks++;
    if ({grant, push} !== 3'b011) $display("FAIL rstmid_restart: got grant=%b push=%b, want 01/1", grant, push);
    else n_pass++;
    drain(40, left);
    n_checks++;
    if (left !== 0) $display("FAIL rstmid_drain: got %0d missing, want 0", left);
    else n_pass++;
    $display("test_reset_mid done");
  endtask

  task automatic test_hold_off();
    int left;
    q0.push_back({1'b0, 8'h30}); exp_q.push_back({2'b01, 8'h30});
    q0.push_back({1'b0, 8'h31}); exp_q.push_back({2'b01, 8'h31});
    q0.push_back({1'b1, 8'h32}); exp_q.push_back({2'b01, 8'h32});
    exp_q.push_back({2'b10, 8'h40});
    tick();
    q1.push_back({1'b1, 8'h40});
    tick();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({grant, push, s1_ready, s0_ready, s1_valid} !== 6'b011011)
        $display("FAIL hold_s0_byte%0d: got grant=%b push=%b s1_ready=%b s0_ready=%b, want 01/1/0/1",
                 i, grant, push, s1_ready, s0_ready);
      else n_pass++;
      tick();
    end
    n_checks++;
    if ({grant, busy, s1_ready, push} !== 5'b00000)
      $display("FAIL hold_idle_gap: got grant=%b busy=%b s1_ready=%b push=%b, want 00/0/0/0",
               grant, busy, s1_ready, push);
    else n_pass++;
    tick();
    n_checks++;
    if ({grant, s1_ready, push} !== 4'b1011)
      $display("FAIL hold_s1_grant: got grant=%b s1_ready=%b push=%b, want 10/1/1", grant, s1_ready, push);
    else n_pass++;
    drain(20, left);
    n_checks++;
    if (left !== 0) $display("FAIL hold_drain: got %0d missing, want 0", left);
    else n_pass++;
    $display("test_hold_off done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, want finish");
    $fatal(1);
  end

  initial begin
    clk          = 1'b0;
    reset        = 1'b1;
    tx_fifo_full = 1'b0;
    full_n       = 1'b0;
    en0          = 1'b1;
    en1          = 1'b1;
    n_checks     = 0;
    n_pass       = 0;
    to_cnt       = 0;
    drive_srcs();

    test_reset();
    test_single_packet();
    test_contention();
    test_stall();
    test_timeout();
    test_reset_mid();
    test_hold_off();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
